// File: rtl/outport_allocator_pkg.sv
// Shared state encoding and width helpers for the output-port allocator.
package outport_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RELEASE = 2'd2
  } alloc_state_e;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/outport_rr_arbiter.sv
// Request arbiter for one output port. OUTPORT_ALLOC_ROUND_ROBIN_EN selects a rotating
// pointer; otherwise fixed priority (lowest index wins) with no state.
module outport_rr_arbiter
  import outport_allocator_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
`ifdef OUTPORT_ALLOC_ROUND_ROBIN_EN
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 update,
  input  logic [NUM_PORTS-1:0] winner,
`endif
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef OUTPORT_ALLOC_ROUND_ROBIN_EN
  localparam int PW = idx_w(NUM_PORTS);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW:0]   idx;
  logic          found;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (winner[i]) win_idx = PW'(i);
  end

  // Pointer moves one past the port that just finished its packet.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)     ptr <= '0;
    else if (update) ptr <= (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + PW'(1);
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/outport_allocator.sv
// Credit-based output-port allocator: grants one input port per packet and strobes its
// flits while downstream credits last. Arbitration mode set by OUTPORT_ALLOC_ROUND_ROBIN_EN.
module outport_allocator
  import outport_allocator_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int CREDIT_DEPTH = 4,
  parameter int PKT_FLITS    = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                port_request_din,
  input  logic                                credit_in_din,
  output logic [NUM_PORTS-1:0]                transfer_strobe_vector_dout,
  output logic [NUM_PORTS-1:0]                xbar_conf_vector_dout,
  output logic                                port_status_dout,
  output logic [credit_w(CREDIT_DEPTH)-1:0]   credit_count_dout
);

  localparam int CW = credit_w(CREDIT_DEPTH);
  localparam int FW = idx_w(PKT_FLITS);

  alloc_state_e         state;
  logic [FW-1:0]        flit_cnt;
  logic [CW-1:0]        credits;
  logic [NUM_PORTS-1:0] grant;
  logic                 has_credit;
  logic                 strobe;
  logic                 credit_ret;

  outport_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
`ifdef OUTPORT_ALLOC_ROUND_ROBIN_EN
    .gclk   (clk),
    .grst_n (reset),
    .update (state == ST_RELEASE),
    .winner (xbar_conf_vector_dout),
`endif
    .req    (port_request_din),
    .grant  (grant)
  );

  assign has_credit = |credits;
  assign strobe     = (state == ST_XFER) && has_credit;
  assign credit_ret = credit_in_din && (credits != CW'(CREDIT_DEPTH));

  assign transfer_strobe_vector_dout = strobe ? xbar_conf_vector_dout : '0;
  assign port_status_dout            = ~|xbar_conf_vector_dout && has_credit;
  assign credit_count_dout           = credits;

  // A returned credit and a strobe in the same cycle cancel, even at full count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           credits <= CW'(CREDIT_DEPTH);
    else if (strobe && !credit_in_din)    credits <= credits - CW'(1);
    else if (credit_ret && !strobe)       credits <= credits + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= ST_IDLE;
      xbar_conf_vector_dout <= '0;
      flit_cnt              <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|port_request_din && has_credit) begin
            xbar_conf_vector_dout <= grant;
            state                 <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (strobe) begin
            flit_cnt <= flit_cnt + FW'(1);
            if (flit_cnt == FW'(PKT_FLITS - 1)) state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          xbar_conf_vector_dout <= '0;
          flit_cnt              <= '0;
          state                 <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
